uart_tx_fifo: RTL and testbench

- Byte-oriented UART transmitter (8N1, LSB first) with a small write FIFO.
- Consumes CPU store traffic: the top-level decodes a data-memory write to the UART address and drives wr_en/wr_data.
- Drives uo_out[4], which currently idles high, so tx must rest at 1.
- Decouples single-cycle CPU writes from multi-thousand-cycle serial frames.

---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : 8N1 LSB-first UART transmitter fed by a small circular write FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [C_BAUD_W-1:0] C_BAUD_MAX = C_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [C_CNT_W-1:0]  C_DEPTH    = C_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [C_BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic [C_PTR_W-1:0]     wptr_q, rptr_q;
    logic [C_CNT_W-1:0]     count_q, count_d;
    logic                   ovf_q;
    logic [7:0]             mem_q [FIFO_DEPTH];

    logic                   w_full, w_empty, w_push, w_drop, w_pop, w_bit_end;

    assign w_full    = (count_q == C_DEPTH);
    assign w_empty   = (count_q == '0);
    // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a write.
    assign w_push    = wr_en & ~w_full;
    assign w_drop    = wr_en & w_full;
    assign w_bit_end = (baud_q == C_BAUD_MAX);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                baud_d = w_bit_end ? '0 : baud_q + 1'b1;
                if (w_bit_end) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                baud_d = w_bit_end ? '0 : baud_q + 1'b1;
                if (w_bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                baud_d = w_bit_end ? '0 : baud_q + 1'b1;
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
            if (w_drop)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= wr_data;
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Directed stimulus with a queue scoreboard and a serial-line monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_count;
    logic       overflow;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [7:0] first, input int n, input int nexp);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            if (i < nexp) exp_q.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_until(input int target);
        int g = 0;
        while (cyc < target && g < 5000) begin
            tick();
            g++;
        end
    endtask

    task automatic wait_busy_low(input string name, input int exp_cyc);
        int g = 0;
        while (busy && g < 2000) begin
            tick();
            g++;
        end
        chk(name, cyc, exp_cyc);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_tx", tx, 1);
            chk("idle_busy", busy, 0);
            chk("idle_empty", fifo_empty, 1);
            chk("idle_count", fifo_count, 0);
            chk("idle_ovf", overflow, 0);
            tick();
        end
    endtask

    // Serial-line monitor: decodes each frame and retires it against the scoreboard.
    initial begin
        logic [9:0] frame;
        logic       stable;
        logic       aborted;
        logic [7:0] expb;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                frame   = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < CPB; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (k == 0) frame[b] = tx;
                        else if (tx !== frame[b]) stable = 1'b0;
                    end
                    if (aborted) break;
                end
                if (aborted) begin
                    exp_q.delete();
                end else begin
                    chk("bit_timing", stable, 1);
                    chk("start_bit", frame[0], 0);
                    chk("stop_bit", frame[9], 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", frame[8:1], 32'hFFFF_FFFF);
                    end else begin
                        expb = exp_q.pop_front();
                        chk("rx_byte", frame[8:1], expb);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_check(50);

        // Single byte: latency and frame length
        t0 = cyc;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        tick();
        wr_en = 1'b0;
        chk("wr_empty", fifo_empty, 0);
        chk("wr_count", fifo_count, 1);
        chk("wr_tx_still_idle", tx, 1);
        chk("wr_busy_low", busy, 0);
        tick();
        chk("pop_tx_fall", tx, 0);
        chk("pop_busy", busy, 1);
        chk("pop_empty", fifo_empty, 1);
        wait_busy_low("single_busy_fall", t0 + 42);

        // Five writes: one pops at once, four fill the FIFO
        tick();
        t0 = cyc;
        burst(8'h01, 5, 5);
        chk("five_full", fifo_full, 1);
        chk("five_count", fifo_count, 4);
        chk("five_ovf", overflow, 0);
        wait_busy_low("five_busy_fall", t0 + 202);
        chk("five_end_empty", fifo_empty, 1);

        // Six writes: last one dropped, overflow sticky until cleared
        tick();
        t0 = cyc;
        burst(8'h10, 6, 5);
        chk("six_ovf", overflow, 1);
        chk("six_count", fifo_count, 4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("six_ovf_clr", overflow, 0);
        wait_busy_low("six_busy_fall", t0 + 202);

        // Write while full on the edge where STOP completes and pops
        tick();
        t0 = cyc;
        burst(8'h20, 5, 5);
        wait_until(t0 + 41);
        chk("edge_pre_full", fifo_full, 1);
        chk("edge_pre_ovf", overflow, 0);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("edge_ovf", overflow, 1);
        chk("edge_count", fifo_count, DEPTH - 1);
        chk("edge_full", fifo_full, 0);
        wait_busy_low("edge_busy_fall", t0 + 202);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("edge_ovf_clr", overflow, 0);

        // Asynchronous reset during DATA bit 3 of 0x5A
        tick();
        t0 = cyc;
        burst(8'h5A, 1, 1);
        wait_until(t0 + 17);
        chk("abort_bit2", tx, 0);
        wait_until(t0 + 20);
        chk("abort_bit3", tx, 1);
        chk("abort_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_empty", fifo_empty, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_check(50);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
